// File: rtl/ndata_compactor.sv
// Sparse-to-dense stream compactor: kept lanes are packed from lane 0 and carried
// across input beats until a full beat (or the packet end) can be emitted.
module ndata_compactor #(
    parameter type         data_t       = logic [31:0],
    parameter int unsigned NUM_ELEMENTS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // Handshake: a beat moves on a rising edge where valid && ready; valid never
    // waits for ready. in_ready is combinational from out_ready and the FSM state.
    input  logic                            in_valid,
    output logic                            in_ready,
    input  data_t                           in_data [NUM_ELEMENTS],
    input  logic [NUM_ELEMENTS-1:0]         in_keep,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output data_t                           out_data [NUM_ELEMENTS],
    output logic [NUM_ELEMENTS-1:0]         out_keep,
    output logic                            out_last,
    output logic                            dbg_state,
    output logic [$clog2(NUM_ELEMENTS)-1:0] dbg_cnt
);

    localparam int N  = NUM_ELEMENTS;
    localparam int CW = $clog2(N);
    localparam int TW = $clog2(2 * N);
    localparam int M  = 2 * N - 1;
    localparam logic [TW-1:0] N_T = TW'(N);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    data_t           res_q [N-1];
    data_t           res_d [N-1];
    logic            ov_q, ov_d;
    data_t           od_q [N];
    data_t           od_d [N];
    logic [N-1:0]    ok_q, ok_d;
    logic            ol_q, ol_d;

    data_t           merged [M];
    logic [TW-1:0]   pos;
    logic [TW-1:0]   total;
    logic [N-1:0]    total_mask;
    logic [N-1:0]    cnt_mask;
    logic            out_free;
    logic            in_fire;

    // Residual elements first, then the kept input lanes in ascending order.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            merged[i] = '0;
        end
        for (int i = 0; i < N - 1; i++) begin
            if (i < int'(cnt_q)) begin
                merged[i] = res_q[i];
            end
        end
        pos = TW'(cnt_q);
        for (int j = 0; j < N; j++) begin
            if (in_keep[j]) begin
                merged[pos] = in_data[j];
                pos         = pos + TW'(1);
            end
        end
        total = pos;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            total_mask[i] = (int'(total) > i);
            cnt_mask[i]   = (int'(cnt_q) > i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ov_d     = ov_q;
        od_d     = od_q;
        ok_d     = ok_q;
        ol_d     = ol_q;
        out_free = !ov_q || out_ready;
        in_ready = (state_q == RUN) && out_free;
        in_fire  = in_valid && in_ready;

        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (in_fire) begin
                    if (total >= N_T) begin
                        ov_d = 1'b1;
                        for (int i = 0; i < N; i++) begin
                            od_d[i] = merged[i];
                        end
                        ok_d = '1;
                        ol_d = in_last && (total == N_T);
                        for (int i = 0; i < N - 1; i++) begin
                            res_d[i] = merged[N + i];
                        end
                        cnt_d = CW'(total - N_T);
                        // Leftover elements of a closing beat need their own beat.
                        if (in_last && (total > N_T)) begin
                            state_d = FLUSH;
                        end
                    end else if (!in_last) begin
                        for (int i = 0; i < N - 1; i++) begin
                            res_d[i] = merged[i];
                        end
                        cnt_d = CW'(total);
                    end else begin
                        // Short closing beat; total==0 still emits so last is never lost.
                        ov_d = 1'b1;
                        for (int i = 0; i < N; i++) begin
                            od_d[i] = merged[i];
                        end
                        ok_d  = total_mask;
                        ol_d  = 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    ov_d = 1'b1;
                    for (int i = 0; i < N - 1; i++) begin
                        od_d[i] = res_q[i];
                    end
                    od_d[N-1] = '0;
                    ok_d      = cnt_mask;
                    ol_d      = 1'b1;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ok_q    <= '0;
            ol_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                od_q[i] <= '0;
            end
            for (int i = 0; i < N - 1; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ok_q    <= ok_d;
            ol_q    <= ol_d;
            od_q    <= od_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_keep  = ok_q;
    assign out_last  = ol_q;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_ndata_compactor.sv
// Directed and randomized bench for ndata_compactor (N=4, 32-bit elements) with an
// element-level reference queue producing the expected output beats.
module tb_ndata_compactor;

    localparam int N  = 4;
    localparam int EW = N * 32 + N + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data [N];
    logic [3:0]  in_keep = 4'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data [N];
    logic [3:0]  out_keep;
    logic        out_last;
    logic        dbg_state;
    logic [1:0]  dbg_cnt;

    int          total_cnt = 0;
    int          bad_cnt = 0;
    bit          rand_bp = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   elem_q[$];

    ndata_compactor #(
        .data_t       (logic [31:0]),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack_beat(input logic [127:0] d, input logic [3:0] k,
                                                input logic l);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (k[i]) m[i*32 +: 32] = d[i*32 +: 32];
        end
        return {m, k, l};
    endfunction

    function automatic logic [127:0] beat_data(input logic [31:0] base);
        logic [127:0] d;
        for (int i = 0; i < N; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) else begin
            bad_cnt++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a flat element queue, cut into 4-wide beats; a closing beat
    // flushes whatever is left (possibly nothing) with last set.
    task automatic model_accept();
        logic [127:0] d;
        int           n;
        bit           closed;
        closed = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (in_keep[j]) elem_q.push_back(in_data[j]);
        end
        while (elem_q.size() >= N) begin
            for (int i = 0; i < N; i++) d[i*32 +: 32] = elem_q.pop_front();
            closed = in_last && (elem_q.size() == 0);
            exp_q.push_back(pack_beat(d, 4'hf, closed));
        end
        if (in_last && !closed) begin
            d = '0;
            n = elem_q.size();
            for (int i = 0; i < n; i++) d[i*32 +: 32] = elem_q.pop_front();
            exp_q.push_back(pack_beat(d, 4'((1 << n) - 1), 1'b1));
        end
    endtask

    task automatic sb_check();
        logic [127:0]  d;
        logic [EW-1:0] obs;
        logic [EW-1:0] expv;
        for (int i = 0; i < N; i++) d[i*32 +: 32] = out_data[i];
        obs = pack_beat(d, out_keep, out_last);
        if (exp_q.size() == 0) expv = 'x;
        else expv = exp_q.pop_front();
        total_cnt++;
        assert (obs === expv) else begin
            bad_cnt++;
            $error("FAIL sb_beat obs=%h exp=%h", obs, expv);
        end
    endtask

    // One clock: observe transfers at the falling edge, return just after the rising edge.
    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (rst_n && out_valid && out_ready) sb_check();
        if (rst_n && acc) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [3:0] k, input logic l);
        bit acc;
        int budget;
        for (int i = 0; i < N; i++) in_data[i] = d[i*32 +: 32];
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        acc      = 1'b0;
        budget   = 0;
        while (!acc && budget < 50) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            cycle(acc);
            budget++;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        int budget;
        for (int i = 0; i < N; i++) in_data[i] = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_keep",  64'(out_keep),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_data0", 64'(out_data[0]), 64'd0);
        chk("rst_out_data3", 64'(out_data[3]), 64'd0);
        chk("rst_cnt",       64'(dbg_cnt),   64'd0);
        chk("rst_state",     64'(dbg_state), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Dense pass-through with one-cycle latency
        for (int b = 0; b < 4; b++) begin
            send(beat_data(32'(16 * b)), 4'hf, b == 3);
            if (b == 0) begin
                chk("lat_valid", 64'(out_valid), 64'd1);
                chk("lat_lane1", 64'(out_data[1]), 64'h1);
            end
        end
        drain(2);
        chk("dense_idle", 64'(out_valid), 64'd0);

        // Sparse merge, then an all-zero beat that must change nothing
        send(beat_data(32'hA0), 4'b0101, 1'b0);
        chk("sparse_cnt_a", 64'(dbg_cnt), 64'd2);
        send(beat_data(32'hB0), 4'b1110, 1'b0);
        chk("sparse_valid", 64'(out_valid), 64'd1);
        chk("sparse_cnt_b", 64'(dbg_cnt), 64'd1);
        send(beat_data(32'hEE0), 4'b0000, 1'b0);
        chk("zero_no_out", 64'(out_valid), 64'd0);
        chk("zero_cnt",    64'(dbg_cnt),   64'd1);
        send(beat_data(32'hEE0), 4'b0000, 1'b1);
        drain(2);

        // Overflow into FLUSH
        send(beat_data(32'hC0), 4'b0111, 1'b0);
        chk("ovf_cnt3", 64'(dbg_cnt), 64'd3);
        send(beat_data(32'hD0), 4'b1111, 1'b1);
        chk("flush_in_ready", 64'(in_ready),  64'd0);
        chk("flush_state",    64'(dbg_state), 64'd1);
        cycle(acc);
        chk("post_flush_ready", 64'(in_ready),  64'd1);
        chk("post_flush_state", 64'(dbg_state), 64'd0);
        chk("post_flush_cnt",   64'(dbg_cnt),   64'd0);
        drain(2);

        // Empty last with cnt=0 and with cnt=2
        send(beat_data(32'h60), 4'b0000, 1'b1);
        drain(1);
        send(beat_data(32'hE0), 4'b0011, 1'b0);
        chk("empty_cnt2", 64'(dbg_cnt), 64'd2);
        send(beat_data(32'h61), 4'b0000, 1'b1);
        drain(2);

        // total==N with last: one full closing beat, no FLUSH
        send(beat_data(32'h100), 4'b1100, 1'b0);
        send(beat_data(32'h110), 4'b0011, 1'b1);
        chk("exact_state", 64'(dbg_state), 64'd0);
        chk("exact_cnt",   64'(dbg_cnt),   64'd0);
        drain(2);

        // cnt==N-1 plus an all-keep beat keeps N-1 residual
        send(beat_data(32'h200), 4'b0111, 1'b0);
        send(beat_data(32'h210), 4'b1111, 1'b0);
        chk("max_total_cnt", 64'(dbg_cnt), 64'd3);
        send(beat_data(32'h220), 4'b0000, 1'b1);
        drain(2);

        // Backpressure: output held, input stalled for 5 cycles
        send(beat_data(32'hF0), 4'b1111, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = 32'h50 + 32'(i);
        in_keep  = 4'hf;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle(acc);
            chk("bp_no_accept", 64'(acc),         64'd0);
            chk("bp_in_ready",  64'(in_ready),    64'd0);
            chk("bp_valid",     64'(out_valid),   64'd1);
            chk("bp_hold_data", 64'(out_data[1]), 64'hF1);
            chk("bp_hold_last", 64'(out_last),    64'd0);
        end
        out_ready = 1'b1;
        send(beat_data(32'h50), 4'hf, 1'b1);
        drain(2);

        // Random keep patterns under random backpressure
        rand_bp = 1'b1;
        for (int b = 0; b < 24; b++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
                 (b == 23) || ($urandom_range(0, 5) == 0));
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            cycle(acc);
            budget++;
        end
        drain(2);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while in FLUSH
        send(beat_data(32'h70), 4'b0111, 1'b0);
        send(beat_data(32'h80), 4'b1111, 1'b1);
        chk("arst_pre_state", 64'(dbg_state), 64'd1);
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_cnt",   64'(dbg_cnt),   64'd0);
        chk("arst_state", 64'(dbg_state), 64'd0);
        chk("arst_keep",  64'(out_keep),  64'd0);
        exp_q.delete();
        elem_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(beat_data(32'h90), 4'b1111, 1'b1);
        chk("arst_fresh_keep", 64'(out_keep), 64'hf);
        chk("arst_fresh_last", 64'(out_last), 64'd1);
        drain(3);
        chk("arst_drained", 64'(exp_q.size()), 64'd0);
        chk("arst_idle",    64'(out_valid),    64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
